// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares single-port data_memory between m0 (single beats) and m1 (bursts).
// Optional ARB_STATS_EN adds saturating per-requester grant counters.
module data_memory_arbiter #(
    parameter int BURST_W      = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int STATS_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               m0_req,
    input  logic               m0_we,
    input  logic [31:0]        m0_adress,
    input  logic [31:0]        m0_wdata,
    output logic               m0_gnt,
    output logic               m0_rvalid,
    output logic [31:0]        m0_rdata,
    input  logic               m1_req,
    input  logic               m1_we,
    input  logic [31:0]        m1_adress,
    input  logic [BURST_W-1:0] m1_burst_len,
    input  logic [31:0]        m1_wdata,
    output logic               m1_gnt,
    output logic               m1_rvalid,
    output logic [31:0]        m1_rdata,
    output logic               mem_write_enable,
    output logic [31:0]        mem_adress,
    output logic [31:0]        mem_write_data,
    input  logic [31:0]        mem_read_data
`ifdef ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] m0_grant_count,
    output logic [STATS_W-1:0] m1_grant_count
`endif
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic {IDLE, BURST} state_t;
    state_t             state;
    logic [BURST_W-1:0] len, beat;
    logic [31:0]        base;
    logic               burst_we;
    logic [SW-1:0]      starve;
    logic               m1_win, g0, g1, in_burst;
    always_comb begin
        in_burst         = state == BURST;
        m1_win           = m1_req && (starve == SW'(STARVE_LIMIT) || !m0_req);
        g1               = !reset && (in_burst ? m1_req : m1_win);
        g0               = !reset && !in_burst && m0_req && !m1_win;
        mem_write_enable = g0 ? m0_we : g1 ? (in_burst ? burst_we : m1_we) : 1'b0;
        mem_adress       = g0 ? (m0_adress & ~32'h3)
                         : g1 ? (in_burst ? base + (32'(beat) << 2) : (m1_adress & ~32'h3))
                         : 32'h0;
        mem_write_data   = g0 ? m0_wdata : g1 ? m1_wdata : 32'h0;
    end
    assign m0_gnt = g0;
    assign m1_gnt = g1;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            len       <= '0;
            beat      <= '0;
            base      <= '0;
            burst_we  <= 1'b0;
            starve    <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= g0 && !m0_we;
            m1_rvalid <= g1 && !mem_write_enable;
            if (g0 && !m0_we) m0_rdata <= mem_read_data;
            if (g1 && !mem_write_enable) m1_rdata <= mem_read_data;
            starve <= g1 ? '0 : (m1_req && starve != SW'(STARVE_LIMIT)) ? starve + 1'b1 : starve;
            if (!in_burst) begin
                if (g1) begin
                    base     <= m1_adress & ~32'h3;
                    burst_we <= m1_we;
                    len      <= m1_burst_len;
                    beat     <= BURST_W'(1);
                    if (m1_burst_len != '0) state <= BURST;
                end
            end else if (!m1_req || beat == len) begin
                state <= IDLE;
            end else begin
                beat <= beat + 1'b1;
            end
        end
    end
`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_grant_count <= '0;
            m1_grant_count <= '0;
        end else begin
            if (g0 && m0_grant_count != '1) m0_grant_count <= m0_grant_count + 1'b1;
            if (g1 && m1_grant_count != '1) m1_grant_count <= m1_grant_count + 1'b1;
        end
    end
`endif
endmodule
